// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, FSM states and shared constants for the parametrised SAP core.
package sap_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_T0, S_T1, S_T2, S_T3, S_T4, S_HALT
    } state_t;

endpackage

// File: rtl/sap_ram.sv
// sap_ram: program/data store; synchronous write, asynchronous read, never reset.
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_core_param.sv
// sap_core_param: width/depth-generic SAP accumulator CPU with in-band loader and single-step.
module sap_core_param
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              done_load,
    input  logic              step_en,
    input  logic              step,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              cf,
    output logic              zf,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);

    state_t            state;
    logic [ADDR_W-1:0] pc, mar, lcnt;
    logic [DATA_W-1:0] a, b, ir;
    logic [DATA_W-1:0] ram_rdata, ram_wdata;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic              ram_we;
    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] opnd;
    logic              sub, jmp, enter_load;
    logic [DATA_W:0]   sum;

    assign opc  = ir[DATA_W-1 -: OPC_W];
    assign opnd = ir[ADDR_W-1:0];
    assign sub  = opc == OP_SUB;
    assign sum  = {1'b0, a} + {1'b0, sub ? ~b : b} + {{DATA_W{1'b0}}, sub};
    assign jmp  = opc == OP_JMP || (opc == OP_JC && cf) || (opc == OP_JZ && zf);
    // prog_en only interrupts at instruction boundaries (T0) or from IDLE/HALT
    assign enter_load = prog_en && (state == S_IDLE || state == S_T0 || state == S_HALT);

    assign ram_we    = (state == S_LOAD && prog_valid) || (state == S_T3 && opc == OP_STA);
    assign ram_waddr = state == S_LOAD ? lcnt : opnd;
    assign ram_wdata = state == S_LOAD ? prog_data : a;
    assign ram_raddr = state == S_T1 ? mar : opnd;

    assign prog_ready = state == S_LOAD;
    assign halted     = state == S_HALT;
    assign dbg_pc     = pc;

    sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            mar       <= '0;
            lcnt      <= '0;
            a         <= '0;
            b         <= '0;
            ir        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            done_load <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (enter_load) begin
                state     <= S_LOAD;
                lcnt      <= '0;
                pc        <= '0;
                done_load <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_T0;
                    S_LOAD: begin
                        if (prog_valid) begin
                            lcnt <= lcnt + ADDR_W'(1);
                            if (&lcnt) done_load <= 1'b1;
                        end
                        if (!prog_en) state <= S_IDLE;
                    end
                    S_T0: if (!step_en || step) begin
                        mar   <= pc;
                        state <= S_T1;
                    end
                    S_T1: begin
                        ir    <= ram_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= S_T2;
                    end
                    S_T2: begin
                        state <= S_T0;
                        if (opc == OP_LDI) a <= DATA_W'(opnd);
                        if (jmp) pc <= opnd;
                        if (opc == OP_OUT) begin
                            out_data  <= a;
                            out_valid <= 1'b1;
                        end
                        if (opc == OP_HLT) state <= S_HALT;
                        if (opc == OP_LDA || opc == OP_STA || opc == OP_ADD || sub) state <= S_T3;
                    end
                    S_T3: begin
                        state <= S_T0;
                        if (opc == OP_LDA) a <= ram_rdata;
                        if (opc == OP_ADD || sub) begin
                            b     <= ram_rdata;
                            state <= S_T4;
                        end
                    end
                    S_T4: begin
                        a     <= sum[DATA_W-1:0];
                        cf    <= sum[DATA_W];
                        zf    <= sum[DATA_W-1:0] == '0;
                        state <= S_T0;
                    end
                    S_HALT: state <= S_HALT;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap_core_param.sv
// tb_sap_core_param: directed program runs with an output scoreboard, on default and 12/6 builds.
module tb_sap_core_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_en, prog_valid, step_en, step;
    logic [7:0]  prog_data;
    logic        prog_ready, done_load, out_valid, cf, zf, halted;
    logic [7:0]  out_data;
    logic [3:0]  dbg_pc;

    logic        prog_en2, prog_valid2;
    logic [11:0] prog_data2;
    logic        prog_ready2, done_load2, out_valid2, cf2, zf2, halted2;
    logic [11:0] out_data2;
    logic [5:0]  dbg_pc2;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0]  q1 [$];
    logic [11:0] q2 [$];
    logic [7:0]  img [16];
    logic        ov1_q = 1'b0;
    logic        ov2_q = 1'b0;

    always #5 clk = ~clk;

    sap_core_param dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .done_load(done_load), .step_en(step_en), .step(step),
        .out_data(out_data), .out_valid(out_valid), .cf(cf), .zf(zf), .halted(halted), .dbg_pc(dbg_pc)
    );

    sap_core_param #(.DATA_W(12), .ADDR_W(6)) dut2 (
        .clk(clk), .rst(rst), .prog_en(prog_en2), .prog_valid(prog_valid2), .prog_data(prog_data2),
        .prog_ready(prog_ready2), .done_load(done_load2), .step_en(1'b0), .step(1'b0),
        .out_data(out_data2), .out_valid(out_valid2), .cf(cf2), .zf(zf2), .halted(halted2), .dbg_pc(dbg_pc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ck(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            n_chk++;
            assert (q1.size() > 0 && out_data === q1[0] && !ov1_q) else begin
                n_err++;
                $error("FAIL out1 observed=%0h expected=%0h (queued=%0d, held=%0b)",
                       out_data, q1.size() > 0 ? q1[0] : 8'hxx, q1.size(), ov1_q);
            end
            if (q1.size() > 0) void'(q1.pop_front());
        end
        if (out_valid2) begin
            n_chk++;
            assert (q2.size() > 0 && out_data2 === q2[0] && !ov2_q) else begin
                n_err++;
                $error("FAIL out2 observed=%0h expected=%0h (queued=%0d, held=%0b)",
                       out_data2, q2.size() > 0 ? q2[0] : 12'hxxx, q2.size(), ov2_q);
            end
            if (q2.size() > 0) void'(q2.pop_front());
        end
        ov1_q <= out_valid;
        ov2_q <= out_valid2;
    end

    task automatic load1(input int gap);
        prog_en = 1'b1;
        for (int i = 0; i < 50 && !prog_ready; i++) ck(1);
        chk("load_ready", prog_ready, 1);
        chk("load_done_clr", done_load, 0);
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1;
            prog_data  = img[i];
            ck(1);
            if (gap > 0 && i % gap == 0) begin
                prog_valid = 1'b0;
                ck(1);
            end
            if (i == 14) chk("done_early", done_load, 0);
        end
        chk("done_load", done_load, 1);
        prog_valid = 1'b0;
        prog_en    = 1'b0;
    endtask

    task automatic run_halt(input string tag);
        for (int i = 0; i < 300 && !halted; i++) ck(1);
        chk(tag, halted, 1);
    endtask

    initial begin
        rst = 1'b1; prog_en = 1'b1; prog_valid = 1'b0; prog_data = '0; step_en = 1'b0; step = 1'b0;
        prog_en2 = 1'b1; prog_valid2 = 1'b0; prog_data2 = '0;
        ck(3);
        chk("rst_ready", prog_ready, 0);
        chk("rst_done", done_load, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_out", out_data, 0);
        chk("rst_flags", {cf, zf}, 0);
        chk("rst_pc", dbg_pc, 0);
        chk("rst2_pc", dbg_pc2, 0);
        rst = 1'b0;

        // 5 + 3 = 8
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[14] = 8'h05; img[15] = 8'h03;
        load1(3);
        q1.push_back(8'h08);
        run_halt("p1_halt");
        chk("p1_flags", {cf, zf}, 2'b00);
        chk("p1_pc", dbg_pc, 4);
        ck(5);
        chk("p1_pc_hold", dbg_pc, 4);

        // SUB equal -> zf, cf; JZ 7 taken
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'h1D; img[1] = 8'h3D; img[2] = 8'h87; img[3] = 8'hF0;
        img[7] = 8'h59; img[8] = 8'hE0; img[9] = 8'hF0; img[13] = 8'h40;
        load1(5);
        q1.push_back(8'h09);
        run_halt("p2_halt");
        chk("p2_flags", {cf, zf}, 2'b11);
        chk("p2_pc", dbg_pc, 4'hA);

        // FF+01 carry, JC taken, self-modifying STA 0 then JMP F / NOP wraps to HLT at 0
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'h1C; img[1] = 8'h2D; img[2] = 8'h75; img[3] = 8'hF0; img[4] = 8'hF0;
        img[5] = 8'hE0; img[6] = 8'h1E; img[7] = 8'h40; img[8] = 8'h6F;
        img[12] = 8'hFF; img[13] = 8'h01; img[14] = 8'hF0; img[15] = 8'h00;
        load1(0);
        q1.push_back(8'h00);
        run_halt("p3_halt");
        chk("p3_flags", {cf, zf}, 2'b11);
        chk("p3_pc_wrap", dbg_pc, 1);

        // single-step
        foreach (img[i]) img[i] = 8'h00;
        img[1] = 8'h57; img[2] = 8'hE0; img[3] = 8'hF0;
        step_en = 1'b1;
        load1(0);
        ck(10);
        chk("step_wait_a", dbg_pc, 0);
        ck(10);
        chk("step_wait_b", dbg_pc, 0);
        chk("step_wait_halt", halted, 0);
        step = 1'b1; ck(1); step = 1'b0; ck(1);
        step = 1'b1; ck(1); step = 1'b0;
        ck(10);
        chk("step_1", dbg_pc, 1);
        step = 1'b1; ck(1); step = 1'b0; ck(5);
        chk("step_2", dbg_pc, 2);
        q1.push_back(8'h07);
        step = 1'b1; ck(1); step = 1'b0; ck(5);
        chk("step_3", dbg_pc, 3);
        chk("step_out", out_data, 8'h07);
        step_en = 1'b0;
        run_halt("step_release");
        chk("step_pc", dbg_pc, 4);

        // rst in T3 of ADD; RAM survives and the re-run reproduces 0x08
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[14] = 8'h05; img[15] = 8'h03;
        load1(0);
        ck(9);
        rst = 1'b1;
        ck(1);
        chk("mid_rst_out", out_data, 0);
        chk("mid_rst_flags", {cf, zf}, 0);
        chk("mid_rst_pc", dbg_pc, 0);
        chk("mid_rst_done", done_load, 0);
        chk("mid_rst_halted", halted, 0);
        rst = 1'b0;
        q1.push_back(8'h08);
        run_halt("rerun_halt");
        chk("rerun_flags", {cf, zf}, 2'b00);

        // 12-bit / 64-word build
        for (int i = 0; i < 50 && !prog_ready2; i++) ck(1);
        chk("w_ready", prog_ready2, 1);
        for (int i = 0; i < 64; i++) begin
            prog_valid2 = 1'b1;
            prog_data2  = i == 0 ? 12'h52A : i == 1 ? 12'hE00 : i == 2 ? 12'hF00 : 12'h000;
            ck(1);
            if (i == 62) chk("w_done_early", done_load2, 0);
        end
        chk("w_done", done_load2, 1);
        prog_valid2 = 1'b0;
        prog_en2    = 1'b0;
        q2.push_back(12'h02A);
        for (int i = 0; i < 100 && !halted2; i++) ck(1);
        chk("w_halt", halted2, 1);
        chk("w_pc", dbg_pc2, 3);
        chk("w_out", out_data2, 12'h02A);
        prog_en2 = 1'b1;
        for (int i = 0; i < 20 && !prog_ready2; i++) ck(1);
        chk("w_reload", prog_ready2, 1);
        chk("w_reload_done", done_load2, 0);
        chk("w_reload_halt", halted2, 0);
        prog_en2 = 1'b0;

        ck(2);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
